window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3x3 neighbourhood generator for the morphology path. Accepts a raster-order 8-bit pixel stream, holds the two previous image rows in line buffers, and presents each complete 3x3 window as nine parallel bytes g0..g8 to the morphology operators (erosion/dilation) that consume a window per operation. A one-deep output register with valid/ready back-pressure absorbs the multi-cycle latency of those consumers.

## Interface
- IMG_W, 128: image width in pixels (>= 3)
- IMG_H, 128: image height in rows (>= 3)
- THRESH, 8'd128: binarisation threshold (used only with WIN_BINARIZE_EN)
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- clr_i  in  1  synchronous frame restart: counters to 0, drops win_valid_o
- pix_i  in  8  input pixel
- pix_valid_i  in  1  pix_i valid
- pix_ready_o  out  1  block can accept pix_i this cycle
- g0_o..g8_o  out  8 each  window: g0 top-left, g1 top-centre, g2 top-right, g3 mid-left, g4 centre, g5 mid-right, g6 bottom-left, g7 bottom-centre, g8 bottom-right
- win_valid_o  out  1  window outputs valid, held until taken
- win_ready_i  in  1  consumer takes window when win_valid_o & win_ready_i
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Accept = pix_valid_i & pix_ready_o; pix_ready_o = !win_valid_o | win_ready_i (combinational).
- Counters x in 0..IMG_W-1, y in 0..IMG_H-1; advance on accept in raster order; x wraps to 0 and y increments at x=IMG_W-1; both wrap to 0 after (IMG_W-1, IMG_H-1).
- On accept of pixel p at (x,y): read lb1[x] (row y-2), lb0[x] (row y-1); write lb1[x]<=lb0[x], lb0[x]<=p (read-before-write, same cycle).
- 3x3 shift register: columns shift left; new right column = {lb1[x], lb0[x], p} top to bottom. Shifts on every accept, across row boundaries.
- Emission: if x>=2 and y>=2, the accepted pixel completes the window centred at (x-1, y-1); g0..g8 load that window, win_valid_o=1. Otherwise win_valid_o follows handshake only (cleared if taken). Stale columns from the previous row are never emitted because x>=2 is required.
- Windows per frame: (IMG_W-2)*(IMG_H-2); no border/padding windows.
- Line buffer contents are not reset; rows y<2 are never used for emission.
- clr_i: x,y<=0, win_valid_o<=0, shift register and g outputs unchanged; clr_i has priority over a simultaneous accept (pixel discarded).

## Timing
- Reset values: win_valid_o=0, frame_done_o=0, g0_o..g8_o=0, x=y=0; hence pix_ready_o=1 out of reset.
- Latency: window valid 1 cycle after the accept of its bottom-right pixel.
- Throughput: 1 pixel/cycle while win_ready_i=1 or no window pending.
- Stall: with window pending and win_ready_i=0, pix_ready_o=0; g outputs and win_valid_o stable.
- Take and accept in same cycle: new window (if emitted) replaces old; otherwise win_valid_o<=0.
- frame_done_o: high the cycle after accept of (IMG_W-1, IMG_H-1), coincident with the last window's win_valid_o.
- rst_ni low mid-frame: immediate return to reset values; next accepted pixel is (0,0).

## Configuration
- WIN_BINARIZE_EN defined: each accepted pixel is replaced by 8'hFF if pix_i >= THRESH else 8'h00 before entering line buffers and shift register; windows are strictly 0/255 as erosion/dilation require.
- Not defined: pixels pass unmodified; THRESH unused.

## Structure
- Shared package win_pkg: pix_t (8-bit), WIN_SIZE=9, window index constants (WIN_TL..WIN_BR), win_t array-of-pix_t typedef.
- One sub-module: line_buffer (depth IMG_W, 8-bit, single address, read-before-write, write-enable = accept); instantiated twice, chained.

## Test plan
- Reset then 5x5 frame, pixel value = 10*y+x, win_ready_i=1 -> 9 windows; first has g0=0, g4=11, g8=22; last has g4=33; frame_done_o pulses with 9th.
- Same frame with win_ready_i toggling 1-in-4 -> pix_ready_o low while window pending, g outputs stable, identical 9-window sequence.
- Two back-to-back 5x5 frames -> second frame's first window at its (2,2) pixel, no window mixes frames at y<2.
- clr_i asserted at pixel (3,2) together with pix_valid_i -> pixel discarded, win_valid_o=0 next cycle, next pixel treated as (0,0).
- rst_ni pulsed low mid-row -> outputs return to reset values asynchronously; following full frame yields correct windows.
- WIN_BINARIZE_EN, THRESH=128, inputs 127/128 alternating -> window bytes only 8'h00 (127) and 8'hFF (128).

Source files
------------

// File: rtl/win_pkg.sv
// Shared types for the 3x3 window generator.
//   pix_t          : one 8-bit pixel
//   win_t          : nine pixels, index 0 = top-left ... 8 = bottom-right (row major)
//   WIN_TL..WIN_BR : named window positions
//   pix_condition  : optional binarisation applied to incoming pixels
package win_pkg;

    typedef logic [7:0] pix_t;

    localparam int WIN_SIZE = 9;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    typedef pix_t [WIN_SIZE-1:0] win_t;

    // With bin_en set the pixel becomes strictly 0 or 255 so that erosion and
    // dilation downstream see a binary image; otherwise it passes unchanged.
    function automatic pix_t pix_condition(input pix_t p, input pix_t thresh, input logic bin_en);
        if (!bin_en)
            return p;
        return (p >= thresh) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage for the window generator.
//   clk_i  : clock
//   we_i   : write enable (pixel accepted)
//   addr_i : column index
//   din_i  : value written at addr_i
//   dout_o : value currently stored at addr_i (combinational, so a write in
//            the same cycle returns the old row's value: read-before-write)
// Contents are intentionally not reset; rows that have not been written in
// the current frame are never used for a window.
module line_buffer
    import win_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  pix_t          din_i,
    output pix_t          dout_o
);

    pix_t mem [DEPTH];

    assign dout_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i)
            mem[addr_i] <= din_i;
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator for the morphology path.
// Raster-order pixels in, one complete 3x3 window out per accepted pixel at
// x>=2, y>=2, held in a one-deep valid/ready output register.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   clr_i                : synchronous frame restart (wins over a pixel in the same cycle)
//   pix_i, pix_valid_i   : pixel input, pix_ready_o back-pressure
//   g0_o..g8_o           : window, g0 top-left ... g8 bottom-right
//   win_valid_o/ready_i  : output handshake
//   frame_done_o         : pulse the cycle after the last pixel of a frame
// Build option: define WIN_BINARIZE_EN to threshold incoming pixels against
// THRESH into 8'h00/8'hFF before they are stored.
module window_3x3_gen
    import win_pkg::*;
#(
    parameter int   IMG_W  = 128,
    parameter int   IMG_H  = 128,
    parameter pix_t THRESH = 8'd128
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  pix_t pix_i,
    input  logic pix_valid_i,
    output logic pix_ready_o,
    output pix_t g0_o,
    output pix_t g1_o,
    output pix_t g2_o,
    output pix_t g3_o,
    output pix_t g4_o,
    output pix_t g5_o,
    output pix_t g6_o,
    output pix_t g7_o,
    output pix_t g8_o,
    output logic win_valid_o,
    input  logic win_ready_i,
    output logic frame_done_o
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

`ifdef WIN_BINARIZE_EN
    localparam logic BIN_EN = 1'b1;
`else
    localparam logic BIN_EN = 1'b0;
`endif

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          accept;
    logic          take_pix;
    logic          emit;
    logic          last_pix;
    pix_t          pix_in;
    pix_t          row_m1;
    pix_t          row_m2;
    win_t          sr_q;
    win_t          sr_nxt;
    win_t          win_q;

    assign pix_ready_o = !win_valid_o || win_ready_i;
    assign accept      = pix_valid_i && pix_ready_o;
    // A pixel presented together with clr_i is discarded entirely.
    assign take_pix    = accept && !clr_i;
    assign emit        = (x_q >= X_TWO) && (y_q >= Y_TWO);
    assign last_pix    = (x_q == X_LAST) && (y_q == Y_LAST);
    assign pix_in      = pix_condition(pix_i, THRESH, BIN_EN);

    // lb0 holds row y-1; its old contents cascade into lb1 (row y-2).
    line_buffer #(.DEPTH(IMG_W), .AW(XW)) u_lb0 (
        .clk_i  (clk_i),
        .we_i   (take_pix),
        .addr_i (x_q),
        .din_i  (pix_in),
        .dout_o (row_m1)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(XW)) u_lb1 (
        .clk_i  (clk_i),
        .we_i   (take_pix),
        .addr_i (x_q),
        .din_i  (row_m1),
        .dout_o (row_m2)
    );

    // Columns move left; the new right column is {row y-2, row y-1, pixel}.
    always_comb begin
        sr_nxt         = sr_q;
        sr_nxt[WIN_TL] = sr_q[WIN_TC];
        sr_nxt[WIN_TC] = sr_q[WIN_TR];
        sr_nxt[WIN_TR] = row_m2;
        sr_nxt[WIN_ML] = sr_q[WIN_MC];
        sr_nxt[WIN_MC] = sr_q[WIN_MR];
        sr_nxt[WIN_MR] = row_m1;
        sr_nxt[WIN_BL] = sr_q[WIN_BC];
        sr_nxt[WIN_BC] = sr_q[WIN_BR];
        sr_nxt[WIN_BR] = pix_in;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q         <= '0;
            win_q        <= '0;
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else if (clr_i) begin
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= accept && last_pix;
            if (accept)
                sr_q <= sr_nxt;
            if (accept && emit) begin
                win_q       <= sr_nxt;
                win_valid_o <= 1'b1;
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end

    assign g0_o = win_q[WIN_TL];
    assign g1_o = win_q[WIN_TC];
    assign g2_o = win_q[WIN_TR];
    assign g3_o = win_q[WIN_ML];
    assign g4_o = win_q[WIN_MC];
    assign g5_o = win_q[WIN_MR];
    assign g6_o = win_q[WIN_BL];
    assign g7_o = win_q[WIN_BC];
    assign g8_o = win_q[WIN_BR];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 5x5 image.
module tb_window_3x3_gen;

    localparam int W = 5;
    localparam int H = 5;
    localparam int EXP_WINDOWS = 9 + 9 + 18 + 10 + 3 + 9 + 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pix = 8'd0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] g0, g1, g2, g3, g4, g5, g6, g7, g8;
    logic       win_valid;
    logic       win_ready = 1'b1;
    logic       frame_done;

    int total = 0;
    int bad = 0;
    int n_taken = 0;
    int rdy_mode = 0;
    int cyc = 0;

    logic [71:0] sbq[$];
    logic [7:0]  fdq[$];
    logic [7:0]  img [H][W];
    int bx = 0;
    int by = 0;

    wire [71:0] cur = {g0, g1, g2, g3, g4, g5, g6, g7, g8};

    window_3x3_gen #(.IMG_W(W), .IMG_H(H), .THRESH(8'd128)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .pix_i        (pix),
        .pix_valid_i  (pix_valid),
        .pix_ready_o  (pix_ready),
        .g0_o         (g0),
        .g1_o         (g1),
        .g2_o         (g2),
        .g3_o         (g3),
        .g4_o         (g4),
        .g5_o         (g5),
        .g6_o         (g6),
        .g7_o         (g7),
        .g8_o         (g8),
        .win_valid_o  (win_valid),
        .win_ready_i  (win_ready),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    // Consumer: always ready, or ready one cycle in four.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            win_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        end
    end

    function automatic logic [7:0] xform(input logic [7:0] v);
`ifdef WIN_BINARIZE_EN
        return (v >= 8'd128) ? 8'hFF : 8'h00;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] pixval(input int kind, input int base, input int x, input int y);
        if (kind == 1)
            return ((x + y) % 2 == 1) ? 8'd128 : 8'd127;
        return 8'(base + 10 * y + x);
    endfunction

    task automatic model_accept(input logic [7:0] v);
        img[by][bx] = xform(v);
        if (bx >= 2 && by >= 2)
            sbq.push_back({img[by-2][bx-2], img[by-2][bx-1], img[by-2][bx],
                           img[by-1][bx-2], img[by-1][bx-1], img[by-1][bx],
                           img[by][bx-2],   img[by][bx-1],   img[by][bx]});
        if (bx == W - 1 && by == H - 1)
            fdq.push_back(img[by-1][bx-1]);
        if (bx == W - 1) begin
            bx = 0;
            by = (by == H - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic send(input logic [7:0] v);
        bit ok;
        int n;
        ok = 0;
        n = 0;
        pix = v;
        pix_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: pix_ready stayed %0b, required 1", pix_ready);
        end else begin
            model_accept(v);
        end
    endtask

    task automatic send_frame(input int kind, input int base, input int npix);
        for (int i = 0; i < npix; i++)
            send(pixval(kind, base, i % W, i / W));
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || fdq.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sbq.size() != 0 || fdq.size() != 0) begin
            bad++;
            $display("FAIL drain: windows left=%0d done pulses left=%0d, required 0/0", sbq.size(), fdq.size());
        end
    endtask

    // Monitor: compares every taken window against the scoreboard.
    initial begin
        logic        prev_stall;
        logic [71:0] prev_win;
        logic [71:0] e;
        logic [7:0]  ec;
        prev_stall = 1'b0;
        prev_win = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (win_valid && !win_ready) begin
                    total++;
                    if (pix_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_ready: pix_ready=%0b, required 0", pix_ready);
                    end
                end
                if (prev_stall) begin
                    total++;
                    if (win_valid !== 1'b1 || cur !== prev_win) begin
                        bad++;
                        $display("FAIL stall_hold: valid=%0b win=%h, required 1 %h", win_valid, cur, prev_win);
                    end
                end
                if (frame_done) begin
                    total++;
                    if (fdq.size() == 0) begin
                        bad++;
                        $display("FAIL frame_done_unexpected: pulse seen, required none");
                    end else begin
                        ec = fdq.pop_front();
                        if (win_valid !== 1'b1 || g4 !== ec) begin
                            bad++;
                            $display("FAIL frame_done_window: valid=%0b g4=%0d, required 1 %0d", win_valid, g4, ec);
                        end
                    end
                end
                if (win_valid && win_ready) begin
                    total++;
                    n_taken++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL window_unexpected: got %h, required no window", cur);
                    end else begin
                        e = sbq.pop_front();
                        if (cur !== e) begin
                            bad++;
                            $display("FAIL window: got %h, required %h", cur, e);
                        end
                    end
                end
                prev_stall = win_valid && !win_ready;
                prev_win = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic check_reset_values(input string name);
        total++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || pix_ready !== 1'b1 || cur !== 72'd0) begin
            bad++;
            $display("FAIL %s: valid=%0b done=%0b ready=%0b win=%h, required 0 0 1 0", name,
                     win_valid, frame_done, pix_ready, cur);
        end
    endtask

    initial begin
        #12;
        check_reset_values("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full frame, always ready.
        send_frame(0, 0, W * H);
        drain();

        // Same frame, consumer ready one cycle in four.
        rdy_mode = 1;
        send_frame(0, 0, W * H);
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Two back-to-back frames with distinct values.
        for (int i = 0; i < W * H; i++)
            send(pixval(0, 0, i % W, i / W));
        for (int i = 0; i < W * H; i++)
            send(pixval(0, 100, i % W, i / W));
        pix_valid = 1'b0;
        drain();

        // clr_i together with pixel (3,2): pixel dropped, window cleared.
        send_frame(0, 50, 2 * W + 3);
        pix = 8'd99;
        pix_valid = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        pix_valid = 1'b0;
        total++;
        if (win_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_valid: win_valid=%0b, required 0", win_valid);
        end
        bx = 0;
        by = 0;
        drain();
        send_frame(0, 20, W * H);
        drain();

        // Asynchronous reset in the middle of row 3.
        send_frame(0, 30, 3 * W + 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        sbq.delete();
        fdq.delete();
        bx = 0;
        by = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, 60, W * H);
        drain();

        // Alternating 127/128 pattern (binarised when the option is built in).
        send_frame(1, 0, W * H);
        drain();

        total++;
        if (n_taken != EXP_WINDOWS) begin
            bad++;
            $display("FAIL window_count: got %0d, required %0d", n_taken, EXP_WINDOWS);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

endmodule
